// File: rtl/geom_volume_seq_pkg.sv
// Shared definitions for the frustum-volume / circle-area calculator:
// state encodings, error codes and the fixed-point pi constants.
package geom_volume_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_RR  = 3'd1,
    S_RX  = 3'd2,
    S_XX  = 3'd3,
    S_H   = 3'd4,
    S_K   = 3'd5,
    S_OUT = 3'd6
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_DEGN = 2'b10;

  // pi and pi/3 truncated to 32 fraction bits; shifting right keeps the floor exact for FRAC <= 32.
  localparam logic [63:0] PI_Q32  = 64'h0000_0003_243F_6A88;
  localparam logic [63:0] PI3_Q32 = 64'h0000_0001_0C15_2382;

  function automatic logic [63:0] piQ(input int frac);
    return PI_Q32 >> (32 - frac);
  endfunction

  function automatic logic [63:0] pi3Q(input int frac);
    return PI3_Q32 >> (32 - frac);
  endfunction

endpackage

// File: rtl/geom_volume_seq_mul.sv
// Shared multiplier with operand selection driven by the sequencer state.
// Purely combinational; the product is truncated to the accumulator width.
module geom_volume_seq_mul
  import geom_volume_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int AW    = 3*WIDTH + FRAC + 4
) (
  input  logic [2:0]       sel,
  input  logic             mode,
  input  logic [AW-1:0]    acc,
  input  logic [WIDTH-1:0] rLarge,
  input  logic [WIDTH-1:0] rSmall,
  input  logic [WIDTH-1:0] height,
  output logic [AW-1:0]    product
);

  localparam logic [AW-1:0] PI_W  = AW'(piQ(FRAC));
  localparam logic [AW-1:0] PI3_W = AW'(pi3Q(FRAC));
  localparam logic [AW-1:0] ONE_W = AW'(1);

  logic [AW-1:0] opA;
  logic [AW-1:0] opB;
  logic [AW-1:0] rLargeW;
  logic [AW-1:0] rSmallW;
  logic [AW-1:0] heightW;

  assign rLargeW = {{(AW-WIDTH){1'b0}}, rLarge};
  assign rSmallW = {{(AW-WIDTH){1'b0}}, rSmall};
  assign heightW = {{(AW-WIDTH){1'b0}}, height};

  // Circle mode reuses the same schedule: the cross terms add zero and h becomes 1.
  always_comb begin
    opA = '0;
    opB = '0;
    case (state_t'(sel))
      S_RR: begin
        opA = rLargeW;
        opB = rLargeW;
      end
      S_RX: begin
        opA = rLargeW;
        opB = mode ? '0 : rSmallW;
      end
      S_XX: begin
        opA = rSmallW;
        opB = mode ? '0 : rSmallW;
      end
      S_H: begin
        opA = acc;
        opB = mode ? ONE_W : heightW;
      end
      S_K: begin
        opA = acc;
        opB = mode ? PI_W : PI3_W;
      end
      default: begin
        opA = '0;
        opB = '0;
      end
    endcase
  end

  assign product = opA * opB;

endmodule

// File: rtl/geom_volume_seq.sv
// Multi-cycle frustum volume / circle area calculator with start/busy/done handshake.
// One multiply per cycle through the shared unit; result and error code registered at S_OUT.
module geom_volume_seq
  import geom_volume_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] r_large,
  input  logic [WIDTH-1:0] r_small,
  input  logic [WIDTH-1:0] height,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] volume,
  output logic [1:0]       err
);

  localparam int AW = 3*WIDTH + FRAC + 4;

  state_t           state;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    product;
  logic             modeQ;
  logic [WIDTH-1:0] rLargeQ;
  logic [WIDTH-1:0] rSmallQ;
  logic [WIDTH-1:0] heightQ;

  logic [AW-1:0]    quot;
  logic             qOverflow;
  logic             degenerate;
  logic             accept;

  assign accept = (state == IDLE) && start;

  geom_volume_seq_mul #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .AW    (AW)
  ) uMul (
    .sel     (state),
    .mode    (modeQ),
    .acc     (acc),
    .rLarge  (rLargeQ),
    .rSmall  (rSmallQ),
    .height  (heightQ),
    .product (product)
  );

  // Operands are captured once at acceptance so later input changes cannot disturb the result.
  always_ff @(posedge clk) begin
    if (accept) begin
      modeQ   <= mode;
      rLargeQ <= r_large;
      rSmallQ <= r_small;
      heightQ <= height;
    end
  end

  assign quot       = acc >> FRAC;
  assign qOverflow  = |quot[AW-1:WIDTH];
  assign degenerate = modeQ ? (rLargeQ == '0)
                            : ((heightQ == '0) || ((rLargeQ == '0) && (rSmallQ == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      volume <= '0;
      err    <= ERR_OK;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= S_RR;
            busy  <= 1'b1;
          end
        end
        S_RR: begin
          acc   <= product;
          state <= S_RX;
        end
        S_RX: begin
          acc   <= acc + product;
          state <= S_XX;
        end
        S_XX: begin
          acc   <= acc + product;
          state <= S_H;
        end
        S_H: begin
          acc   <= product;
          state <= S_K;
        end
        S_K: begin
          acc   <= product;
          state <= S_OUT;
        end
        S_OUT: begin
          // Degenerate geometry outranks overflow.
          if (degenerate) begin
            volume <= '0;
            err    <= ERR_DEGN;
          end else if (qOverflow) begin
            volume <= '1;
            err    <= ERR_OVF;
          end else begin
            volume <= quot[WIDTH-1:0];
            err    <= ERR_OK;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_geom_volume_seq.sv
// Directed plus randomized checks of the geometry calculator against an
// arithmetic reference computed straight from the volume/area formulas.
module tb_geom_volume_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [31:0] rL;
  logic [31:0] rS;
  logic [31:0] ht;
  logic        busy;
  logic        done;
  logic [31:0] volume;
  logic [1:0]  err;

  int total = 0;
  int bad   = 0;

  geom_volume_seq #(.WIDTH(32), .FRAC(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .r_large (rL),
    .r_small (rS),
    .height  (ht),
    .busy    (busy),
    .done    (done),
    .volume  (volume),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: floor(pi_q * h * (R^2 + Rr + r^2) / 2^16) or floor(pi_q * R^2 / 2^16).
  function automatic void model(input logic m, input logic [31:0] R, input logic [31:0] r,
                                input logic [31:0] h, output logic [31:0] v, output logic [1:0] e);
    logic [127:0] bR, bS, bH, p, q;
    logic deg;
    bR = 128'(R);
    bS = 128'(r);
    bH = 128'(h);
    if (m) begin
      deg = (R == 0);
      p   = bR * bR * 128'(205887);
    end else begin
      deg = (h == 0) || (R == 0 && r == 0);
      p   = (bR * bR + bR * bS + bS * bS) * bH * 128'(68629);
    end
    q = p >> 16;
    if (deg) begin
      v = 32'd0;
      e = 2'b10;
    end else if (q > 128'hFFFF_FFFF) begin
      v = 32'hFFFF_FFFF;
      e = 2'b01;
    end else begin
      v = q[31:0];
      e = 2'b00;
    end
  endfunction

  task automatic runReq(input string tag, input logic m, input logic [31:0] R,
                        input logic [31:0] r, input logic [31:0] h, input bit restart);
    logic [31:0] ev;
    logic [1:0]  ee;
    model(m, R, r, h, ev, ee);
    @(negedge clk);
    start = 1'b1; mode = m; rL = R; rS = r; ht = h;
    @(posedge clk); #1;
    check({tag, ".busyAcc"}, 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0; mode = $urandom_range(0, 1); rL = $urandom; rS = $urandom; ht = $urandom;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      check({tag, ".doneEarly"}, 64'(done), 64'd0);
      check({tag, ".busyMid"}, 64'(busy), 64'd1);
      if (restart && e == 2) begin
        start = 1'b1; mode = ~m; rL = 32'd7; rS = 32'd3; ht = 32'd9;
      end
      if (restart && e == 5) start = 1'b0;
    end
    @(posedge clk); #1;
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busyEnd"}, 64'(busy), 64'd0);
    check({tag, ".volume"}, 64'(volume), 64'(ev));
    check({tag, ".err"}, 64'(err), 64'(ee));
    @(posedge clk); #1;
    check({tag, ".donePulse"}, 64'(done), 64'd0);
    check({tag, ".busyIdle"}, 64'(busy), 64'd0);
    check({tag, ".volHeld"}, 64'(volume), 64'(ev));
  endtask

  initial begin
    logic        m;
    logic [31:0] R, r, h;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; rL = '0; rS = '0; ht = '0;
    #1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.volume", 64'(volume), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runReq("frustum", 1'b0, 32'd4, 32'd2, 32'd3, 1'b0);
    check("frustum.lit", 64'(volume), 64'd87);
    runReq("circle", 1'b1, 32'd10, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    check("circle.lit", 64'(volume), 64'd314);
    runReq("frusEq", 1'b0, 32'd10, 32'd10, 32'd1, 1'b0);
    check("frusEq.lit", 64'(volume), 64'd314);
    runReq("ovf", 1'b0, 32'd65535, 32'd65535, 32'd65535, 1'b0);
    check("ovf.lit", 64'(err), 64'd1);
    runReq("degH", 1'b0, 32'd5, 32'd3, 32'd0, 1'b0);
    check("degH.lit", 64'(err), 64'd2);
    runReq("degC", 1'b1, 32'd0, 32'd9, 32'd9, 1'b0);
    runReq("degRr", 1'b0, 32'd0, 32'd0, 32'd12, 1'b0);
    runReq("restart", 1'b0, 32'd4, 32'd2, 32'd3, 1'b1);
    check("restart.lit", 64'(volume), 64'd87);

    // Abort a request part-way through with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; rL = 32'd100; rS = 32'd50; ht = 32'd7;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.volume", 64'(volume), 64'd0);
    check("abort.err", 64'(err), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    runReq("afterRst", 1'b0, 32'd4, 32'd2, 32'd3, 1'b0);
    check("afterRst.lit", 64'(volume), 64'd87);

    for (int i = 0; i < 24; i++) begin
      m = 1'(i % 2);
      R = $urandom >> $urandom_range(0, 31);
      r = $urandom >> $urandom_range(0, 31);
      h = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) h = 32'd0;
      if ($urandom_range(0, 9) == 0) R = 32'd0;
      runReq("rand", m, R, r, h, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
